// File: rtl/ssd_display_ctrl.sv
// Two-digit seven-segment sequencing controller: overlay arbitration, sequential
// binary-to-BCD conversion, leading-zero blanking and per-digit blinking.
module ssd_display_ctrl #(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int BLINK_HALF  = 6_250_000,
    parameter bit LZB         = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] a_value,
    input  logic       b_valid,
    input  logic [6:0] b_value,
    output logic       b_ready,
    output logic       overlay_active,
    input  logic [1:0] blink_mask,
    output logic       overflow,
    output logic [3:0] first_digit,
    output logic [3:0] second_digit
);

    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [3:0] BLANK = 4'b1111;

    typedef enum logic [1:0] {
        S_SAMPLE = 2'd0,
        S_DIV    = 2'd1,
        S_COMMIT = 2'd2
    } conv_state_e;

    // Handshake: a request is accepted on a cycle where b_valid & b_ready; the
    // overlay then stays selected for HOLD_CYCLES cycles and b_ready stays low.
    logic              overlay_q, overlay_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [6:0]        b_cap_q, b_cap_d;

    always_comb begin
        overlay_d  = overlay_q;
        hold_cnt_d = hold_cnt_q;
        b_cap_d    = b_cap_q;
        if (overlay_q) begin
            if (hold_cnt_q == '0) begin
                overlay_d = 1'b0;
            end else begin
                hold_cnt_d = hold_cnt_q - 1'b1;
            end
        end else if (b_valid) begin
            b_cap_d    = b_value;
            overlay_d  = 1'b1;
            hold_cnt_d = HOLD_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overlay_q  <= 1'b0;
            hold_cnt_q <= '0;
            b_cap_q    <= '0;
        end else begin
            overlay_q  <= overlay_d;
            hold_cnt_q <= hold_cnt_d;
            b_cap_q    <= b_cap_d;
        end
    end

    // The source is only looked at in SAMPLE, so in-flight conversions are immune
    // to both value changes and overlay switches.
    conv_state_e state_q;
    logic [6:0]  src;
    logic [6:0]  rem_q;
    logic [3:0]  tens_acc_q;
    logic        ovf_pend_q;
    logic [3:0]  held_tens_q;
    logic [3:0]  held_units_q;
    logic        overflow_q;

    assign src = overlay_q ? b_cap_q : a_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_SAMPLE;
            rem_q        <= '0;
            tens_acc_q   <= '0;
            ovf_pend_q   <= 1'b0;
            held_tens_q  <= BLANK;
            held_units_q <= BLANK;
            overflow_q   <= 1'b0;
        end else begin
            case (state_q)
                S_SAMPLE: begin
                    tens_acc_q <= '0;
                    if (src >= 7'd100) begin
                        ovf_pend_q <= 1'b1;
                        state_q    <= S_COMMIT;
                    end else begin
                        rem_q      <= src;
                        ovf_pend_q <= 1'b0;
                        state_q    <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (rem_q >= 7'd10) begin
                        rem_q      <= rem_q - 7'd10;
                        tens_acc_q <= tens_acc_q + 4'd1;
                    end else begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (ovf_pend_q) begin
                        held_tens_q  <= BLANK;
                        held_units_q <= BLANK;
                    end else begin
                        held_tens_q  <= tens_acc_q;
                        held_units_q <= rem_q[3:0];
                    end
                    overflow_q <= ovf_pend_q;
                    state_q    <= S_SAMPLE;
                end
                default: state_q <= S_SAMPLE;
            endcase
        end
    end

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_off_q, phase_off_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_off_d = phase_off_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_off_d = ~phase_off_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_off_q <= phase_off_d;
        end
    end

    logic [3:0] first_q, first_d;
    logic [3:0] second_q, second_d;

    always_comb begin
        first_d  = held_tens_q;
        second_d = held_units_q;
        if ((blink_mask[1] && phase_off_q) || (LZB && (held_tens_q == 4'd0)) || overflow_q) begin
            first_d = BLANK;
        end
        if ((blink_mask[0] && phase_off_q) || overflow_q) begin
            second_d = BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q  <= BLANK;
            second_q <= BLANK;
        end else begin
            first_q  <= first_d;
            second_q <= second_d;
        end
    end

    assign first_digit    = first_q;
    assign second_digit   = second_q;
    assign overflow       = overflow_q;
    assign overlay_active = overlay_q;
    assign b_ready        = ~overlay_q;

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Directed bench for ssd_display_ctrl: two instances (LZB=1 and LZB=0) share stimulus.
module tb_ssd_display_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] a_value = 7'd47;
    logic       b_valid = 1'b0;
    logic [6:0] b_value = 7'd0;
    logic [1:0] blink_mask = 2'b00;

    logic       b_ready, overlay_active, overflow;
    logic [3:0] first_digit, second_digit;
    logic       z_b_ready, z_overlay_active, z_overflow;
    logic [3:0] z_first_digit, z_second_digit;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ssd_display_ctrl #(.HOLD_CYCLES(20), .BLINK_HALF(8), .LZB(1'b1)) dut (
        .clk(clk), .rst(rst), .a_value(a_value), .b_valid(b_valid), .b_value(b_value),
        .b_ready(b_ready), .overlay_active(overlay_active), .blink_mask(blink_mask),
        .overflow(overflow), .first_digit(first_digit), .second_digit(second_digit)
    );

    ssd_display_ctrl #(.HOLD_CYCLES(20), .BLINK_HALF(8), .LZB(1'b0)) dut_nolzb (
        .clk(clk), .rst(rst), .a_value(a_value), .b_valid(b_valid), .b_value(b_value),
        .b_ready(z_b_ready), .overlay_active(z_overlay_active), .blink_mask(blink_mask),
        .overflow(z_overflow), .first_digit(z_first_digit), .second_digit(z_second_digit)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_value = 7'd47;
        blink_mask = 2'b00;
        tick(3);
        checks++;
        if ({first_digit, second_digit, overflow, overlay_active, b_ready} !== {4'hF, 4'hF, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_values got f=%h s=%h ovf=%b act=%b rdy=%b want f=f s=f ovf=0 act=0 rdy=1",
                     first_digit, second_digit, overflow, overlay_active, b_ready);
        end
        rst = 1'b0;
        tick(7);
        checks++;
        if ({first_digit, second_digit} !== 8'hFF) begin
            failures++;
            $display("FAIL reset_pre_commit got f=%h s=%h want f=f s=f", first_digit, second_digit);
        end
        tick(1);
        checks++;
        if ({first_digit, second_digit, overflow} !== {4'h4, 4'h7, 1'b0}) begin
            failures++;
            $display("FAIL first_conv_47 got f=%h s=%h ovf=%b want f=4 s=7 ovf=0", first_digit, second_digit, overflow);
        end
    endtask

    task automatic test_lzb();
        a_value = 7'd5;
        tick(30);
        checks++;
        if ({first_digit, second_digit} !== {4'hF, 4'h5}) begin
            failures++;
            $display("FAIL lzb_on_5 got f=%h s=%h want f=f s=5", first_digit, second_digit);
        end
        checks++;
        if ({z_first_digit, z_second_digit} !== {4'h0, 4'h5}) begin
            failures++;
            $display("FAIL lzb_off_5 got f=%h s=%h want f=0 s=5", z_first_digit, z_second_digit);
        end
        a_value = 7'd0;
        tick(30);
        checks++;
        if ({first_digit, second_digit, z_first_digit, z_second_digit} !== {4'hF, 4'h0, 4'h0, 4'h0}) begin
            failures++;
            $display("FAIL zero_value got f=%h s=%h zf=%h zs=%h want f=f s=0 zf=0 zs=0",
                     first_digit, second_digit, z_first_digit, z_second_digit);
        end
    endtask

    task automatic test_overflow();
        a_value = 7'd100;
        tick(30);
        checks++;
        if ({first_digit, second_digit, overflow} !== {4'hF, 4'hF, 1'b1}) begin
            failures++;
            $display("FAIL ovf_100 got f=%h s=%h ovf=%b want f=f s=f ovf=1", first_digit, second_digit, overflow);
        end
        a_value = 7'd127;
        tick(30);
        checks++;
        if ({z_first_digit, z_second_digit, z_overflow} !== {4'hF, 4'hF, 1'b1}) begin
            failures++;
            $display("FAIL ovf_127 got f=%h s=%h ovf=%b want f=f s=f ovf=1", z_first_digit, z_second_digit, z_overflow);
        end
        a_value = 7'd99;
        tick(30);
        checks++;
        if ({first_digit, second_digit, overflow} !== {4'h9, 4'h9, 1'b0}) begin
            failures++;
            $display("FAIL conv_99 got f=%h s=%h ovf=%b want f=9 s=9 ovf=0", first_digit, second_digit, overflow);
        end
    endtask

    task automatic test_overlay();
        int active_cnt;
        int first_hi;
        int last_hi;
        active_cnt = 0;
        first_hi = -1;
        last_hi = -1;
        a_value = 7'd12;
        tick(30);
        checks++;
        if ({first_digit, second_digit, b_ready} !== {4'h1, 4'h2, 1'b1}) begin
            failures++;
            $display("FAIL pre_overlay_12 got f=%h s=%h rdy=%b want f=1 s=2 rdy=1", first_digit, second_digit, b_ready);
        end
        b_value = 7'd88;
        b_valid = 1'b1;
        tick(1);
        b_valid = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (overlay_active) begin
                active_cnt++;
                if (first_hi < 0) first_hi = i;
                last_hi = i;
            end
            if (i == 3) begin
                b_value = 7'd33;
                b_valid = 1'b1;
            end
            if (i == 4) b_valid = 1'b0;
            if (i == 10) begin
                checks++;
                if (b_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL overlay_ready_low got %b want 0", b_ready);
                end
            end
            if (i == 19) begin
                checks++;
                if ({first_digit, second_digit} !== {4'h8, 4'h8}) begin
                    failures++;
                    $display("FAIL overlay_88 got f=%h s=%h want f=8 s=8", first_digit, second_digit);
                end
            end
            tick(1);
        end
        checks++;
        if (active_cnt != 20 || first_hi != 1 || last_hi != 20) begin
            failures++;
            $display("FAIL overlay_length got cnt=%0d first=%0d last=%0d want cnt=20 first=1 last=20",
                     active_cnt, first_hi, last_hi);
        end
        tick(30);
        checks++;
        if ({first_digit, second_digit, overlay_active, b_ready} !== {4'h1, 4'h2, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL overlay_revert got f=%h s=%h act=%b rdy=%b want f=1 s=2 act=0 rdy=1",
                     first_digit, second_digit, overlay_active, b_ready);
        end
    endtask

    task automatic test_blink();
        logic [3:0] fd[40];
        int last_change;
        int n_changes;
        int blank_cnt;
        int bad_first;
        a_value = 7'd36;
        blink_mask = 2'b00;
        tick(30);
        checks++;
        if ({first_digit, second_digit} !== {4'h3, 4'h6}) begin
            failures++;
            $display("FAIL steady_36 got f=%h s=%h want f=3 s=6", first_digit, second_digit);
        end
        blink_mask = 2'b10;
        tick(2);
        for (int i = 0; i < 40; i++) begin
            fd[i] = first_digit;
            checks++;
            if (second_digit !== 4'h6) begin
                failures++;
                $display("FAIL blink_units_steady cycle=%0d got %h want 6", i, second_digit);
            end
            checks++;
            if (first_digit !== 4'h3 && first_digit !== 4'hF) begin
                failures++;
                $display("FAIL blink_tens_value cycle=%0d got %h want 3 or f", i, first_digit);
            end
            tick(1);
        end
        last_change = -1;
        n_changes = 0;
        for (int i = 1; i < 40; i++) begin
            if (fd[i] !== fd[i-1]) begin
                n_changes++;
                if (last_change >= 0) begin
                    checks++;
                    if (i - last_change != 8) begin
                        failures++;
                        $display("FAIL blink_half_period got %0d want 8", i - last_change);
                    end
                end
                last_change = i;
            end
        end
        checks++;
        if (n_changes < 4) begin
            failures++;
            $display("FAIL blink_toggles got %0d want >=4", n_changes);
        end
        blink_mask = 2'b01;
        tick(2);
        blank_cnt = 0;
        bad_first = 0;
        for (int i = 0; i < 16; i++) begin
            if (second_digit === 4'hF) blank_cnt++;
            else if (second_digit !== 4'h6) bad_first++;
            if (first_digit !== 4'h3) bad_first++;
            tick(1);
        end
        checks++;
        if (blank_cnt != 8 || bad_first != 0) begin
            failures++;
            $display("FAIL blink_units got blank=%0d bad=%0d want blank=8 bad=0", blank_cnt, bad_first);
        end
        blink_mask = 2'b00;
    endtask

    task automatic test_reset_mid();
        a_value = 7'd73;
        tick(30);
        checks++;
        if ({first_digit, second_digit} !== {4'h7, 4'h3}) begin
            failures++;
            $display("FAIL pre_reset_73 got f=%h s=%h want f=7 s=3", first_digit, second_digit);
        end
        b_value = 7'd42;
        b_valid = 1'b1;
        tick(1);
        b_valid = 1'b0;
        tick(3);
        rst = 1'b1;
        #1;
        checks++;
        if ({first_digit, second_digit, overflow, overlay_active, b_ready} !== {4'hF, 4'hF, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL async_reset got f=%h s=%h ovf=%b act=%b rdy=%b want f=f s=f ovf=0 act=0 rdy=1",
                     first_digit, second_digit, overflow, overlay_active, b_ready);
        end
        #1;
        rst = 1'b0;
        tick(10);
        checks++;
        if ({first_digit, second_digit, overlay_active, b_ready} !== {4'hF, 4'hF, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL post_reset_pending got f=%h s=%h act=%b rdy=%b want f=f s=f act=0 rdy=1",
                     first_digit, second_digit, overlay_active, b_ready);
        end
        tick(1);
        checks++;
        if ({first_digit, second_digit, overflow} !== {4'h7, 4'h3, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_73 got f=%h s=%h ovf=%b want f=7 s=3 ovf=0", first_digit, second_digit, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_lzb();
        test_overflow();
        test_overlay();
        test_blink();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
